// File: rtl/uart_rx_buffer_if.sv
// Consumer-side stream of the UART receive buffer: first-word-fall-through valid/ready
// carrying one character plus its parity-error flag.
interface uart_rx_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_perr;

  // Buffer side drives the head entry; consumer side returns ready.
  modport master (
    output out_valid,
    output out_data,
    output out_perr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_perr,
    output out_ready
  );

endinterface

// File: rtl/uart_rx_buffer.sv
// Receive buffer behind uart_top: accepts characters over a 4-phase bundled-data handshake,
// queues them with their parity flag in a power-of-two FIFO and exposes them as FWFT valid/ready.
module uart_rx_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SYNC_STAGE = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     async_rx_d_req,
  input  logic [DATA_WIDTH:0]      async_rx_d,
  output logic                     async_rx_d_ack,
  uart_rx_buffer_if.master         out_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               perr_cnt,
  input  logic                     perr_clr
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef enum logic [0:0] {
    StIdle,
    StWaitLow
  } hs_state_e;

  // ---------------------------------------------------------------------------
  // Request synchronizer; data is bundled and only sampled once req_s is high.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGE-1:0] req_sync_q;
  logic                  req_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGE-2:0], async_rx_d_req};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGE-1];

  // ---------------------------------------------------------------------------
  // FIFO pointers and status
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0]      wr_addr, rd_addr;
  logic                  empty, full;
  logic                  wr_en, pop;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [DATA_WIDTH:0]   head;

  assign wr_addr = wr_ptr_q[AddrW-1:0];
  assign rd_addr = rd_ptr_q[AddrW-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_addr == rd_addr) && (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign pop     = !empty && out_if.out_ready;

  // ---------------------------------------------------------------------------
  // Handshake FSM; full is taken from pre-edge state, so a pop never frees a slot
  // for a write in the same cycle.
  // ---------------------------------------------------------------------------
  hs_state_e state_q, state_d;
  logic      ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_s && !full) begin
          wr_en   = 1'b1;
          state_d = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!req_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ack_d = (state_d == StWaitLow);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  assign async_rx_d_ack = ack_q;

  // ---------------------------------------------------------------------------
  // Storage and pointer update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= async_rx_d;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign head             = mem_q[rd_addr];
  assign out_if.out_valid = !empty;
  assign out_if.out_data  = head[DATA_WIDTH-1:0];
  assign out_if.out_perr  = head[DATA_WIDTH];

  // Pointers wrap modulo 2*DEPTH, so the plain difference is the occupancy.
  assign level = wr_ptr_q - rd_ptr_q;

  // ---------------------------------------------------------------------------
  // Saturating parity-error counter; clear wins over a same-cycle increment.
  // ---------------------------------------------------------------------------
  logic [7:0] perr_cnt_q, perr_cnt_d;

  always_comb begin
    perr_cnt_d = perr_cnt_q;
    if (perr_clr) begin
      perr_cnt_d = 8'd0;
    end else if (wr_en && async_rx_d[DATA_WIDTH] && (perr_cnt_q != 8'hFF)) begin
      perr_cnt_d = perr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perr_cnt_q <= 8'd0;
    end else begin
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign perr_cnt = perr_cnt_q;

  // ---------------------------------------------------------------------------
  // Sanity properties
  // ---------------------------------------------------------------------------
  level_in_range_a: assert property (
    @(posedge clock) disable iff (!reset_n) level <= PtrW'(DEPTH)
  );

  ack_falls_after_req_low_a: assert property (
    @(posedge clock) disable iff (!reset_n) (async_rx_d_ack && !req_s) |=> !async_rx_d_ack
  );

  no_write_when_full_a: assert property (
    @(posedge clock) disable iff (!reset_n) full |-> !wr_en
  );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_rx_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic          clock;
  logic          reset_n;
  logic          async_rx_d_req;
  logic [DW:0]   async_rx_d;
  logic          async_rx_d_ack;
  logic [4:0]    level;
  logic [7:0]    perr_cnt;
  logic          perr_clr;

  logic          rand_mode;
  logic          rand_bit;
  logic          ready_val;

  uart_rx_buffer_if #(.DATA_WIDTH(DW)) rx_if ();

  assign rx_if.out_ready = rand_mode ? rand_bit : ready_val;

  uart_rx_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .SYNC_STAGE(SYNC)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .async_rx_d_req(async_rx_d_req),
    .async_rx_d    (async_rx_d),
    .async_rx_d_ack(async_rx_d_ack),
    .out_if        (rx_if),
    .level         (level),
    .perr_cnt      (perr_cnt),
    .perr_clr      (perr_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: req seen SYNC edges late; a word is queued at the first edge
  // where the delayed req is high, no ack is outstanding and the queue had room.
  // ---------------------------------------------------------------------------
  logic [DW:0]     m_q[$];
  logic [SYNC-1:0] m_sync;
  bit              m_ack;
  int              m_perr;
  bit              m_req_s, m_pop, m_wr;
  int              m_sz;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_sync = '0;
      m_ack  = 1'b0;
      m_perr = 0;
    end else begin
      m_req_s = m_sync[SYNC-1];
      m_sz    = m_q.size();
      m_pop   = (m_sz > 0) && rx_if.out_ready;
      m_wr    = !m_ack && m_req_s && (m_sz < DEPTH);
      if (m_pop) void'(m_q.pop_front());
      if (m_wr) m_q.push_back(async_rx_d);
      if (perr_clr) m_perr = 0;
      else if (m_wr && async_rx_d[DW] && m_perr < 255) m_perr++;
      if (m_wr) m_ack = 1'b1;
      else if (m_ack && !m_req_s) m_ack = 1'b0;
      m_sync = {m_sync[SYNC-2:0], async_rx_d_req};
    end
  end

  logic [DW-1:0] got[$];
  int            max_level;

  always @(negedge clock) begin
    check("ack", async_rx_d_ack, m_ack);
    check("out_valid", rx_if.out_valid, m_q.size() != 0);
    check("level", level, m_q.size());
    check("perr_cnt", perr_cnt, m_perr);
    if (m_q.size() != 0) begin
      check("out_data", rx_if.out_data, m_q[0][DW-1:0]);
      check("out_perr", rx_if.out_perr, m_q[0][DW]);
    end
    if (rx_if.out_valid && rx_if.out_ready) got.push_back(rx_if.out_data);
    if (int'(level) > max_level) max_level = int'(level);
  end

  always @(posedge clock) begin
    #1;
    if (rand_mode) rand_bit = 1'($urandom_range(0, 1));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic wait_ack(input logic val, input string name);
    int n = 0;
    while (async_rx_d_ack !== val && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) check(name, async_rx_d_ack, val);
  endtask

  task automatic hs(input logic [DW:0] d);
    async_rx_d     = d;
    async_rx_d_req = 1'b1;
    wait_ack(1'b1, "hs_ack_rise_timeout");
    async_rx_d_req = 1'b0;
    wait_ack(1'b0, "hs_ack_fall_timeout");
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  logic [DW:0] fill_d[DEPTH];
  logic [DW:0] sent[$];
  logic [DW:0] w;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    async_rx_d_req = 1'b0;
    async_rx_d     = '0;
    perr_clr       = 1'b0;
    rand_mode      = 1'b0;
    rand_bit       = 1'b0;
    ready_val      = 1'b0;
    max_level      = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_ack", async_rx_d_ack, 0);
    check("rst_valid", rx_if.out_valid, 0);
    check("rst_level", level, 0);
    check("rst_perr_cnt", perr_cnt, 0);

    // Single word: ack rises on the third edge after req is first sampled
    async_rx_d     = 9'h0A5;
    async_rx_d_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("single_ack_rise", async_rx_d_ack, (k == 3));
    end
    check("single_valid", rx_if.out_valid, 1);
    check("single_data", rx_if.out_data, 8'hA5);
    check("single_perr", rx_if.out_perr, 0);
    check("single_level", level, 1);
    async_rx_d_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("single_ack_fall", async_rx_d_ack, (k != 3));
    end
    ready_val = 1'b1;
    tick();
    ready_val = 1'b0;
    check("single_pop_level", level, 0);
    check("single_pop_valid", rx_if.out_valid, 0);

    // Fill and stall
    for (int i = 0; i < DEPTH; i++) begin
      fill_d[i] = {1'(i), 8'(i * 17 + 1)};
      hs(fill_d[i]);
    end
    check("fill_level", level, 16);
    async_rx_d     = 9'h1EE;
    async_rx_d_req = 1'b1;
    repeat (10) tick();
    check("stall_ack_low", async_rx_d_ack, 0);
    check("stall_level", level, 16);
    ready_val = 1'b1;
    tick();
    ready_val = 1'b0;
    check("pop_while_full_level", level, 15);
    check("pop_while_full_ack", async_rx_d_ack, 0);
    tick();
    check("stalled_write_ack", async_rx_d_ack, 1);
    check("stalled_write_level", level, 16);
    async_rx_d_req = 1'b0;
    wait_ack(1'b0, "stall_ack_fall_timeout");
    ready_val = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clock);
      w = (i < DEPTH) ? fill_d[i] : 9'h1EE;
      check("drain_order", rx_if.out_data, w[DW-1:0]);
    end
    tick();
    ready_val = 1'b0;
    check("drain_level", level, 0);

    // Wrap-around with random consumer
    got.delete();
    max_level = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = 9'($urandom);
      sent.push_back(w);
      hs(w);
    end
    rand_mode = 1'b0;
    ready_val = 1'b1;
    repeat (40) tick();
    check("wrap_count", got.size(), 40);
    for (int i = 0; i < 40; i++) begin
      if (i < got.size()) check("wrap_order", got[i], sent[i][DW-1:0]);
    end
    check("wrap_max_level_ok", (max_level <= DEPTH), 1);

    // Parity counter saturation and clear priority
    perr_clr = 1'b1;
    tick();
    perr_clr = 1'b0;
    check("perr_cleared", perr_cnt, 0);
    for (int i = 0; i < 300; i++) hs({1'b1, 8'(i)});
    check("perr_saturated", perr_cnt, 255);
    async_rx_d     = 9'h155;
    async_rx_d_req = 1'b1;
    tick();
    tick();
    perr_clr = 1'b1;
    tick();
    perr_clr = 1'b0;
    check("clr_vs_write_ack", async_rx_d_ack, 1);
    check("clr_vs_write_cnt", perr_cnt, 0);
    async_rx_d_req = 1'b0;
    wait_ack(1'b0, "clr_ack_fall_timeout");
    hs(9'h1AA);
    check("perr_after_clr", perr_cnt, 1);
    repeat (4) tick();

    // Reset mid-handshake
    ready_val      = 1'b0;
    async_rx_d     = 9'h13C;
    async_rx_d_req = 1'b1;
    wait_ack(1'b1, "rst_mid_ack_timeout");
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid_ack", async_rx_d_ack, 0);
    check("rst_mid_level", level, 0);
    check("rst_mid_valid", rx_if.out_valid, 0);
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    wait_ack(1'b1, "recapture_ack_timeout");
    check("recapture_level", level, 1);
    check("recapture_data", rx_if.out_data, 8'h3C);
    check("recapture_perr", rx_if.out_perr, 1);
    async_rx_d_req = 1'b0;
    wait_ack(1'b0, "recapture_ack_fall_timeout");

    // Simultaneous push and pop at level 5
    for (int i = 1; i <= 4; i++) hs(9'(9'h040 + i));
    check("pp_level_before", level, 5);
    async_rx_d     = 9'h0F0;
    async_rx_d_req = 1'b1;
    tick();
    tick();
    ready_val = 1'b1;
    tick();
    ready_val = 1'b0;
    check("pp_ack", async_rx_d_ack, 1);
    check("pp_level", level, 5);
    check("pp_head", rx_if.out_data, 8'h41);
    async_rx_d_req = 1'b0;
    wait_ack(1'b0, "pp_ack_fall_timeout");
    ready_val = 1'b1;
    repeat (8) tick();
    check("final_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
